rep_string_seq: RTL and testbench
=================================

// Module: rep_string_seq
// PURPOSE
//  Multi-cycle sequencer for string commands (CMD_MOVS/CMPS/SCAS/STOS/LODS), with or without REP/REPE/REPNE.
//  Runs one element per iteration over a single-outstanding memory hint request/response channel.
//  Updates ECX/ESI/EDI/EAX and ZF, then hands final state back to the decode/execute stage.
// PARAMETERS
//  MAX_ITERS  1024  iteration cap; used only when REP_ITER_LIMIT_EN is defined
// PORTS
//  clk             in   1   clock; single clock domain
//  rst_n           in   1   reset, asynchronous, active-low
//  start_valid     in   1   new string op offered
//  start_ready     out  1   seq idle, accepts op
//  opc             in   6   CMD_* code; sampled with start
//  rep_kind        in   2   00 none, 01 REP/REPE, 10 REPNE, 11 treated as 00
//  elem_size       in   2   0=1B, 1=2B, 2=4B, 3 treated as 4B
//  df              in   1   direction flag: 0 increment, 1 decrement
//  ecx_in,esi_in,edi_in,eax_in  in  32 each  architectural values at start
//  hint_req_valid  out  1   memory request valid
//  hint_req_ready  in   1   request accepted
//  hint_req_is_write out 1  1=write, 0=read
//  hint_req_address out 32  byte address
//  hint_req_data   out  32  write data, zero-extended element
//  hint_rsp_valid  in   1   read data return
//  hint_rsp_data   in   32  read data; low elem_size bytes used
//  done_valid      out  1   final state valid
//  done_ready      in   1   consumer accepts final state
//  ecx_out,esi_out,edi_out,eax_out  out  32 each  final register values
//  zf_out          out  1   ZF from last compare; 0 if no compare performed
//  iter_overflow   out  1   op aborted at MAX_ITERS
// BEHAVIOUR
//  Reset: state IDLE; start_ready=1; all other outputs 0; internal regs 0.
//  Reset mid-op: returns to IDLE immediately; pending request or response dropped.
//  States: IDLE->CHECK->{RD_A->WAIT_A}->{RD_B->WAIT_B}->{WR}->UPDATE->CHECK|DONE.
//  IDLE: start_valid&start_ready latches all inputs; next state CHECK.
//  start_ready is 1 only in IDLE.
//  CHECK: rep_kind!=0 and ECX==0 -> DONE with zero iterations; else begin iteration.
//  Iteration ops:
//    MOVS: rd[ESI], then wr[EDI]=data
//    STOS: wr[EDI]=EAX
//    LODS: rd[ESI] -> EAX low bytes, upper EAX bytes preserved
//    CMPS: rd[ESI], then rd[EDI]; ZF = (a==b)
//    SCAS: rd[EDI]; ZF = (EAX==data)
//    Compares mask to elem_size.
//  Request handshake: valid rises in RD/WR state; addr/data/is_write held stable until ready.
//  Read: after accept, wait in WAIT_x for hint_rsp_valid; hint_rsp_valid outside WAIT_x is ignored.
//  Write: completes on accept; no response expected.
//  UPDATE: each used pointer += df ? -size : +size, mod 2^32 (0x0 - 1 wraps to 0xFFFFFFFF).
//  UPDATE: if rep_kind!=0, ECX -= 1.
//  Loop exit (-> DONE):
//    rep_kind==0
//    ECX==0 after decrement
//    CMPS/SCAS with REPE and ZF==0
//    CMPS/SCAS with REPNE and ZF==1
//  Otherwise -> CHECK.
//  Min latency: start to done_valid = 2 + per-access cycles (1 req + >=1 rsp wait per read, 1 per write) + 1 UPDATE.
//  DONE: done_valid=1; outputs stable until done_ready.
//  On done_ready: -> IDLE, done_valid=0, outputs hold last values.
//  Unknown opc: no memory access; DONE with inputs unchanged, zf_out=0.
// CONFIGURATION
//  REP_ITER_LIMIT_EN defined: iteration counter runs.
//    In CHECK with count==MAX_ITERS and op not finished: -> DONE with iter_overflow=1 and partial registers.
//    iter_overflow clears on done handshake.
//  REP_ITER_LIMIT_EN undefined: no counter; iter_overflow tied 0; no cap.
// TESTING
//  1. REP MOVS, size 4, df=0, ECX=3, ESI=0x100, EDI=0x200, always-ready mem
//     -> rd 0x100/0x104/0x108, wr 0x200/0x204/0x208
//     -> ECX=0, ESI=0x10C, EDI=0x20C.
//  2. REPE CMPS, size 1, ECX=5, mismatch at 3rd byte
//     -> 6 reads; ECX=2, ESI/EDI +3, zf_out=0.
//  3. REP STOS, ECX=0 -> no hint_req_valid; done_valid after CHECK; all regs unchanged.
//  4. LODS, size 2, df=1, ESI=0x0, EAX=0xAABBCCDD, rsp 0x1234
//     -> EAX=0xAABB1234, ESI=0xFFFFFFFE, ECX unchanged.
//  5. hint_req_ready low 4 cycles, then rst_n low mid-WAIT
//     -> request fields stable while stalled; IDLE, start_ready=1, all outputs 0.
//  6. REP_ITER_LIMIT_EN, MAX_ITERS=4, REP STOS with ECX=10
//     -> 4 writes; iter_overflow=1, ECX=6.

Source files
------------

// File: rtl/rep_string_seq.sv
// rep_string_seq: multi-cycle sequencer for x86-style string instructions
// (MOVS/CMPS/SCAS/STOS/LODS) with optional REP/REPE/REPNE prefixes.
//
// One element is processed per iteration over a single-outstanding memory
// request/response channel. ECX/ESI/EDI/EAX and ZF are updated as the op
// runs; the final state is presented on a valid/ready "done" channel.
//
// Opcode encoding (opc):
//   6'h01 CMD_MOVS, 6'h02 CMD_CMPS, 6'h03 CMD_SCAS, 6'h04 CMD_STOS,
//   6'h05 CMD_LODS; any other value is an unknown op (no memory access).
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   start_valid/start_ready      op offer / accept (ready only when idle)
//   opc, rep_kind, elem_size, df op descriptor, sampled on start
//   ecx_in/esi_in/edi_in/eax_in  architectural registers at start
//   hint_req_*                   memory request (valid/ready, held stable)
//   hint_rsp_valid/_data         read data return
//   done_valid/done_ready        final state handshake
//   ecx_out/esi_out/edi_out/eax_out, zf_out, iter_overflow  final state
//
// Configuration macro: REP_ITER_LIMIT_EN -- when defined, an iteration
// counter aborts the op at MAX_ITERS iterations and raises iter_overflow.
module rep_string_seq #(
    parameter int unsigned MAX_ITERS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [5:0]  opc,
    input  logic [1:0]  rep_kind,
    input  logic [1:0]  elem_size,
    input  logic        df,
    input  logic [31:0] ecx_in,
    input  logic [31:0] esi_in,
    input  logic [31:0] edi_in,
    input  logic [31:0] eax_in,
    output logic        hint_req_valid,
    input  logic        hint_req_ready,
    output logic        hint_req_is_write,
    output logic [31:0] hint_req_address,
    output logic [31:0] hint_req_data,
    input  logic        hint_rsp_valid,
    input  logic [31:0] hint_rsp_data,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [31:0] ecx_out,
    output logic [31:0] esi_out,
    output logic [31:0] edi_out,
    output logic [31:0] eax_out,
    output logic        zf_out,
    output logic        iter_overflow
);

    localparam logic [5:0] CMD_MOVS = 6'h01;
    localparam logic [5:0] CMD_CMPS = 6'h02;
    localparam logic [5:0] CMD_SCAS = 6'h03;
    localparam logic [5:0] CMD_STOS = 6'h04;
    localparam logic [5:0] CMD_LODS = 6'h05;

    typedef enum logic [3:0] {
        StIdle,
        StCheck,
        StRdA,
        StWaitA,
        StRdB,
        StWaitB,
        StWr,
        StUpdate,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  opc_q, opc_d;
    logic [1:0]  rep_q, rep_d;
    logic [1:0]  size_q, size_d;
    logic        df_q, df_d;
    logic [31:0] ecx_q, ecx_d;
    logic [31:0] esi_q, esi_d;
    logic [31:0] edi_q, edi_d;
    logic [31:0] eax_q, eax_d;
    logic [31:0] data_a_q, data_a_d;  // first read element, already masked
    logic        zf_q, zf_d;

`ifdef REP_ITER_LIMIT_EN
    logic [31:0] iter_q, iter_d;
    logic        ovf_q, ovf_d;
`endif

    // Element size decode; encoding 3 behaves as 4 bytes.
    logic [31:0] size_bytes;
    logic [31:0] elem_mask;
    always_comb begin
        case (size_q)
            2'd0:    begin size_bytes = 32'd1; elem_mask = 32'h0000_00FF; end
            2'd1:    begin size_bytes = 32'd2; elem_mask = 32'h0000_FFFF; end
            default: begin size_bytes = 32'd4; elem_mask = 32'hFFFF_FFFF; end
        endcase
    end

    logic [31:0] step;
    logic [31:0] ecx_dec;
    assign step    = df_q ? (32'd0 - size_bytes) : size_bytes;
    assign ecx_dec = ecx_q - 32'd1;

    logic op_movs, op_cmps, op_scas, op_stos, op_lods;
    logic op_known, op_cmp, use_esi, use_edi;
    assign op_movs  = (opc_q == CMD_MOVS);
    assign op_cmps  = (opc_q == CMD_CMPS);
    assign op_scas  = (opc_q == CMD_SCAS);
    assign op_stos  = (opc_q == CMD_STOS);
    assign op_lods  = (opc_q == CMD_LODS);
    assign op_known = op_movs | op_cmps | op_scas | op_stos | op_lods;
    assign op_cmp   = op_cmps | op_scas;
    assign use_esi  = op_movs | op_cmps | op_lods;
    assign use_edi  = op_movs | op_cmps | op_stos | op_scas;

    always_comb begin
        state_d           = state_q;
        opc_d             = opc_q;
        rep_d             = rep_q;
        size_d            = size_q;
        df_d              = df_q;
        ecx_d             = ecx_q;
        esi_d             = esi_q;
        edi_d             = edi_q;
        eax_d             = eax_q;
        data_a_d          = data_a_q;
        zf_d              = zf_q;
`ifdef REP_ITER_LIMIT_EN
        iter_d            = iter_q;
        ovf_d             = ovf_q;
`endif
        start_ready       = 1'b0;
        done_valid        = 1'b0;
        hint_req_valid    = 1'b0;
        hint_req_is_write = 1'b0;
        hint_req_address  = 32'd0;
        hint_req_data     = 32'd0;

        unique case (state_q)
            StIdle: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    opc_d    = opc;
                    rep_d    = (rep_kind == 2'b11) ? 2'b00 : rep_kind;
                    size_d   = elem_size;
                    df_d     = df;
                    ecx_d    = ecx_in;
                    esi_d    = esi_in;
                    edi_d    = edi_in;
                    eax_d    = eax_in;
                    data_a_d = 32'd0;
                    zf_d     = 1'b0;
`ifdef REP_ITER_LIMIT_EN
                    iter_d   = 32'd0;
                    ovf_d    = 1'b0;
`endif
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (!op_known || (rep_q != 2'b00 && ecx_q == 32'd0)) begin
                    state_d = StDone;
`ifdef REP_ITER_LIMIT_EN
                end else if (iter_q == MAX_ITERS) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
`endif
                end else if (use_esi) begin
                    state_d = StRdA;
                end else if (op_scas) begin
                    state_d = StRdB;
                end else begin
                    state_d = StWr;
                end
            end
            StRdA: begin
                hint_req_valid   = 1'b1;
                hint_req_address = esi_q;
                if (hint_req_ready) state_d = StWaitA;
            end
            StWaitA: begin
                if (hint_rsp_valid) begin
                    if (op_lods) begin
                        // Only the element bytes of EAX are replaced.
                        eax_d   = (eax_q & ~elem_mask) | (hint_rsp_data & elem_mask);
                        state_d = StUpdate;
                    end else begin
                        data_a_d = hint_rsp_data & elem_mask;
                        state_d  = op_movs ? StWr : StRdB;
                    end
                end
            end
            StRdB: begin
                hint_req_valid   = 1'b1;
                hint_req_address = edi_q;
                if (hint_req_ready) state_d = StWaitB;
            end
            StWaitB: begin
                if (hint_rsp_valid) begin
                    if (op_cmps) begin
                        zf_d = (data_a_q == (hint_rsp_data & elem_mask));
                    end else begin
                        zf_d = ((eax_q & elem_mask) == (hint_rsp_data & elem_mask));
                    end
                    state_d = StUpdate;
                end
            end
            StWr: begin
                hint_req_valid    = 1'b1;
                hint_req_is_write = 1'b1;
                hint_req_address  = edi_q;
                hint_req_data     = op_movs ? data_a_q : (eax_q & elem_mask);
                if (hint_req_ready) state_d = StUpdate;
            end
            StUpdate: begin
                if (use_esi) esi_d = esi_q + step;
                if (use_edi) edi_d = edi_q + step;
                if (rep_q != 2'b00) ecx_d = ecx_dec;
`ifdef REP_ITER_LIMIT_EN
                iter_d = iter_q + 32'd1;
`endif
                if ((rep_q == 2'b00) || (ecx_dec == 32'd0) ||
                    (op_cmp && rep_q == 2'b01 && !zf_q) ||
                    (op_cmp && rep_q == 2'b10 && zf_q)) begin
                    state_d = StDone;
                end else begin
                    state_d = StCheck;
                end
            end
            StDone: begin
                done_valid = 1'b1;
                if (done_ready) begin
`ifdef REP_ITER_LIMIT_EN
                    ovf_d = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            opc_q    <= 6'd0;
            rep_q    <= 2'd0;
            size_q   <= 2'd0;
            df_q     <= 1'b0;
            ecx_q    <= 32'd0;
            esi_q    <= 32'd0;
            edi_q    <= 32'd0;
            eax_q    <= 32'd0;
            data_a_q <= 32'd0;
            zf_q     <= 1'b0;
`ifdef REP_ITER_LIMIT_EN
            iter_q   <= 32'd0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            rep_q    <= rep_d;
            size_q   <= size_d;
            df_q     <= df_d;
            ecx_q    <= ecx_d;
            esi_q    <= esi_d;
            edi_q    <= edi_d;
            eax_q    <= eax_d;
            data_a_q <= data_a_d;
            zf_q     <= zf_d;
`ifdef REP_ITER_LIMIT_EN
            iter_q   <= iter_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ecx_out = ecx_q;
    assign esi_out = esi_q;
    assign edi_out = edi_q;
    assign eax_out = eax_q;
    assign zf_out  = zf_q;

`ifdef REP_ITER_LIMIT_EN
    assign iter_overflow = ovf_q;
`else
    // No iteration cap in this build.
    logic unused_max_iters;
    assign unused_max_iters = ^MAX_ITERS;
    assign iter_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_rep_string_seq.sv
// Self-checking bench for rep_string_seq: directed scenarios plus randomized
// ops checked against a behavioural model of the string-instruction rules.
module tb_rep_string_seq;

    localparam logic [5:0] CMD_MOVS = 6'h01;
    localparam logic [5:0] CMD_CMPS = 6'h02;
    localparam logic [5:0] CMD_SCAS = 6'h03;
    localparam logic [5:0] CMD_STOS = 6'h04;
    localparam logic [5:0] CMD_LODS = 6'h05;
`ifdef REP_ITER_LIMIT_EN
    localparam int unsigned TbMaxIters = 4;
    localparam bit          TbLimit    = 1'b1;
`else
    localparam int unsigned TbMaxIters = 1024;
    localparam bit          TbLimit    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [5:0]  opc = 6'd0;
    logic [1:0]  rep_kind = 2'd0;
    logic [1:0]  elem_size = 2'd0;
    logic        df = 1'b0;
    logic [31:0] ecx_in = 32'd0, esi_in = 32'd0, edi_in = 32'd0, eax_in = 32'd0;
    logic        hint_req_valid;
    logic        hint_req_ready = 1'b0;
    logic        hint_req_is_write;
    logic [31:0] hint_req_address;
    logic [31:0] hint_req_data;
    logic        hint_rsp_valid = 1'b0;
    logic [31:0] hint_rsp_data = 32'd0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [31:0] ecx_out, esi_out, edi_out, eax_out;
    logic        zf_out;
    logic        iter_overflow;

    rep_string_seq #(.MAX_ITERS(TbMaxIters)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_valid       (start_valid),
        .start_ready       (start_ready),
        .opc               (opc),
        .rep_kind          (rep_kind),
        .elem_size         (elem_size),
        .df                (df),
        .ecx_in            (ecx_in),
        .esi_in            (esi_in),
        .edi_in            (edi_in),
        .eax_in            (eax_in),
        .hint_req_valid    (hint_req_valid),
        .hint_req_ready    (hint_req_ready),
        .hint_req_is_write (hint_req_is_write),
        .hint_req_address  (hint_req_address),
        .hint_req_data     (hint_req_data),
        .hint_rsp_valid    (hint_rsp_valid),
        .hint_rsp_data     (hint_rsp_data),
        .done_valid        (done_valid),
        .done_ready        (done_ready),
        .ecx_out           (ecx_out),
        .esi_out           (esi_out),
        .edi_out           (edi_out),
        .eax_out           (eax_out),
        .zf_out            (zf_out),
        .iter_overflow     (iter_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } acc_t;

    int          n_checks = 0;
    int          n_errs = 0;
    int          ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
    bit          rsp_hold = 1'b0;
    int          cur_size = 4;
    int          last_cyc = 0;
    logic [7:0]  mem_seed = 8'h00;
    logic [7:0]  mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    acc_t        obs_q[$];
    acc_t        exp_q[$];
    logic [31:0] e_ecx, e_esi, e_edi, e_eax;
    logic        e_zf, e_ovf;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return mem_seed ^ {6'd0, a[1:0]};
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_seed ^ {6'd0, a[1:0]};
    endfunction

    function automatic logic [31:0] mem_elem(input logic [31:0] a, input int sz);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_rd(a + 32'(i));
        return v;
    endfunction

    function automatic logic [31:0] ref_elem(input logic [31:0] a, input int sz);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
        return v;
    endfunction

    function automatic int size_of(input logic [1:0] es);
        return (es == 2'd0) ? 1 : (es == 2'd1) ? 2 : 4;
    endfunction

    // Memory slave: random ready, random response delay, occasional stray
    // response pulses while no read is outstanding.
    task automatic responder();
        bit          pend = 1'b0;
        int          dly = 0;
        logic [31:0] word = 32'd0;
        forever begin
            @(negedge clk);
            hint_rsp_valid = 1'b0;
            hint_rsp_data  = $urandom;
            if (!rst_n) begin
                pend           = 1'b0;
                hint_req_ready = 1'b0;
            end else begin
                if (pend && !rsp_hold) begin
                    if (dly == 0) begin
                        hint_rsp_valid = 1'b1;
                        hint_rsp_data  = word;
                        pend           = 1'b0;
                    end else begin
                        dly--;
                    end
                end else if (!pend && !rsp_hold && ready_mode == 1 &&
                             $urandom_range(0, 3) == 0) begin
                    hint_rsp_valid = 1'b1;
                end
                case (ready_mode)
                    0:       hint_req_ready = 1'b1;
                    1:       hint_req_ready = 1'($urandom_range(0, 1));
                    default: hint_req_ready = 1'b0;
                endcase
                if (hint_req_valid && hint_req_ready) begin
                    if (hint_req_is_write) begin
                        obs_q.push_back({1'b1, hint_req_address, hint_req_data});
                        for (int i = 0; i < cur_size; i++)
                            mem[hint_req_address + 32'(i)] = hint_req_data[8*i +: 8];
                    end else begin
                        obs_q.push_back({1'b0, hint_req_address, 32'd0});
                        word = $urandom;
                        for (int i = 0; i < cur_size; i++)
                            word[8*i +: 8] = mem_rd(hint_req_address + 32'(i));
                        pend = 1'b1;
                        dly  = (ready_mode == 0) ? 0 : $urandom_range(0, 2);
                    end
                end
            end
        end
    endtask

    // Reference model: architectural semantics of one string instruction.
    task automatic model(input logic [5:0] op, input logic [1:0] rk, input logic [1:0] es,
                         input logic d, input logic [31:0] c, input logic [31:0] s,
                         input logic [31:0] di, input logic [31:0] a);
        int          sz = size_of(es);
        logic [31:0] m = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        logic [31:0] step = d ? (32'd0 - 32'(sz)) : 32'(sz);
        logic [1:0]  rep = (rk == 2'b11) ? 2'b00 : rk;
        bit          is_cmp = (op == CMD_CMPS) || (op == CMD_SCAS);
        bit          known = (op >= CMD_MOVS) && (op <= CMD_LODS);
        logic [31:0] va, vb;
        int          iters = 0;
        exp_q.delete();
        ref_mem = mem;
        e_zf  = 1'b0;
        e_ovf = 1'b0;
        for (int g = 0; g < 4096 && known; g++) begin
            if (rep != 2'b00 && c == 32'd0) break;
            if (TbLimit && iters == int'(TbMaxIters)) begin
                e_ovf = 1'b1;
                break;
            end
            case (op)
                CMD_MOVS: begin
                    va = ref_elem(s, sz);
                    exp_q.push_back({1'b0, s, 32'd0});
                    exp_q.push_back({1'b1, di, va});
                    for (int i = 0; i < sz; i++) ref_mem[di + 32'(i)] = va[8*i +: 8];
                    s  = s + step;
                    di = di + step;
                end
                CMD_STOS: begin
                    va = a & m;
                    exp_q.push_back({1'b1, di, va});
                    for (int i = 0; i < sz; i++) ref_mem[di + 32'(i)] = va[8*i +: 8];
                    di = di + step;
                end
                CMD_LODS: begin
                    exp_q.push_back({1'b0, s, 32'd0});
                    a = (a & ~m) | ref_elem(s, sz);
                    s = s + step;
                end
                CMD_CMPS: begin
                    va = ref_elem(s, sz);
                    vb = ref_elem(di, sz);
                    exp_q.push_back({1'b0, s, 32'd0});
                    exp_q.push_back({1'b0, di, 32'd0});
                    e_zf = (va == vb);
                    s  = s + step;
                    di = di + step;
                end
                default: begin
                    vb = ref_elem(di, sz);
                    exp_q.push_back({1'b0, di, 32'd0});
                    e_zf = ((a & m) == vb);
                    di = di + step;
                end
            endcase
            if (rep != 2'b00) c = c - 32'd1;
            iters++;
            if (rep == 2'b00 || c == 32'd0) break;
            if (is_cmp && rep == 2'b01 && !e_zf) break;
            if (is_cmp && rep == 2'b10 && e_zf) break;
        end
        e_ecx = c;
        e_esi = s;
        e_edi = di;
        e_eax = a;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [1:0] rk,
                          input logic [1:0] es, input logic d, input logic [31:0] c,
                          input logic [31:0] s, input logic [31:0] di, input logic [31:0] a,
                          input int dr_wait);
        int cyc;
        model(op, rk, es, d, c, s, di, a);
        cur_size = size_of(es);
        obs_q.delete();
        @(negedge clk);
        n_checks++;
        if (start_ready !== 1'b1) begin
            n_errs++;
            $display("FAIL %s start_ready: got %b exp 1", tag, start_ready);
        end
        opc = op; rep_kind = rk; elem_size = es; df = d;
        ecx_in = c; esi_in = s; edi_in = di; eax_in = a;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        // Scramble inputs: the op must run from latched values.
        opc = 6'($urandom); rep_kind = 2'($urandom); elem_size = 2'($urandom);
        ecx_in = $urandom; esi_in = $urandom; edi_in = $urandom; eax_in = $urandom;
        cyc = 1;
        while (done_valid !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        last_cyc = cyc;
        n_checks++;
        if (done_valid !== 1'b1) begin
            n_errs++;
            $display("FAIL %s timeout: done_valid got %b exp 1", tag, done_valid);
            do_reset();
            return;
        end
        n_checks++;
        if (ecx_out !== e_ecx) begin
            n_errs++; $display("FAIL %s ecx_out: got %h exp %h", tag, ecx_out, e_ecx);
        end
        n_checks++;
        if (esi_out !== e_esi) begin
            n_errs++; $display("FAIL %s esi_out: got %h exp %h", tag, esi_out, e_esi);
        end
        n_checks++;
        if (edi_out !== e_edi) begin
            n_errs++; $display("FAIL %s edi_out: got %h exp %h", tag, edi_out, e_edi);
        end
        n_checks++;
        if (eax_out !== e_eax) begin
            n_errs++; $display("FAIL %s eax_out: got %h exp %h", tag, eax_out, e_eax);
        end
        n_checks++;
        if ({zf_out, iter_overflow} !== {e_zf, e_ovf}) begin
            n_errs++;
            $display("FAIL %s zf/ovf: got %b%b exp %b%b", tag, zf_out, iter_overflow,
                     e_zf, e_ovf);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errs++;
            $display("FAIL %s access count: got %0d exp %0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errs++;
                $display("FAIL %s access %0d: got %h exp %h", tag, i, obs_q[i], exp_q[i]);
            end
        end
        for (int k = 0; k < dr_wait; k++) @(negedge clk);
        n_checks++;
        if ({done_valid, ecx_out, eax_out} !== {1'b1, e_ecx, e_eax}) begin
            n_errs++;
            $display("FAIL %s done hold: got %b %h %h exp 1 %h %h", tag, done_valid, ecx_out,
                     eax_out, e_ecx, e_eax);
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        n_checks++;
        if ({done_valid, start_ready, iter_overflow, ecx_out, edi_out} !==
            {1'b0, 1'b1, 1'b0, e_ecx, e_edi}) begin
            n_errs++;
            $display("FAIL %s after done: got v%b r%b o%b %h %h exp v0 r1 o0 %h %h", tag,
                     done_valid, start_ready, iter_overflow, ecx_out, edi_out, e_ecx, e_edi);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({hint_req_valid, hint_req_is_write, hint_req_address, hint_req_data, done_valid}
            !== 67'd0) begin
            n_errs++;
            $display("FAIL reset req/done: got %b %b %h %h %b exp all 0", hint_req_valid,
                     hint_req_is_write, hint_req_address, hint_req_data, done_valid);
        end
        n_checks++;
        if ({ecx_out, esi_out, edi_out, eax_out, zf_out, iter_overflow} !== 130'd0) begin
            n_errs++;
            $display("FAIL reset regs: got %h %h %h %h %b %b exp all 0", ecx_out, esi_out,
                     edi_out, eax_out, zf_out, iter_overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({start_ready, done_valid, hint_req_valid} !== 3'b100) begin
            n_errs++;
            $display("FAIL reset idle: got %b%b%b exp 100", start_ready, done_valid,
                     hint_req_valid);
        end
    endtask

    task automatic test_spec_examples();
        logic [7:0] src[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] dst[5] = '{8'h11, 8'h22, 8'h99, 8'h44, 8'h55};
        ready_mode = 0;
        mem.delete();
        run_op("rep_movs", CMD_MOVS, 2'b01, 2'd2, 1'b0, 32'd3, 32'h100, 32'h200, 32'h0, 0);
        n_checks++;
        if ({ecx_out, esi_out, edi_out} !== {32'd0, 32'h10C, 32'h20C}) begin
            n_errs++;
            $display("FAIL rep_movs regs: got %h %h %h exp 0 10c 20c", ecx_out, esi_out,
                     edi_out);
        end

        mem.delete();
        for (int i = 0; i < 5; i++) begin
            mem[32'h400 + 32'(i)] = src[i];
            mem[32'h800 + 32'(i)] = dst[i];
        end
        run_op("repe_cmps", CMD_CMPS, 2'b01, 2'd0, 1'b0, 32'd5, 32'h400, 32'h800, 32'h0, 1);
        n_checks++;
        if ({ecx_out, esi_out, edi_out, zf_out, 32'(obs_q.size())} !==
            {32'd2, 32'h403, 32'h803, 1'b0, 32'd6}) begin
            n_errs++;
            $display("FAIL repe_cmps: got %h %h %h zf%b n%0d exp 2 403 803 zf0 n6", ecx_out,
                     esi_out, edi_out, zf_out, obs_q.size());
        end

        run_op("rep_stos_ecx0", CMD_STOS, 2'b01, 2'd2, 1'b0, 32'd0, 32'h11, 32'h22,
               32'h33, 0);
        n_checks++;
        if ({32'(last_cyc), 32'(obs_q.size()), ecx_out, edi_out, eax_out} !==
            {32'd2, 32'd0, 32'd0, 32'h22, 32'h33}) begin
            n_errs++;
            $display("FAIL rep_stos_ecx0: got cyc%0d n%0d %h %h %h exp cyc2 n0 0 22 33",
                     last_cyc, obs_q.size(), ecx_out, edi_out, eax_out);
        end

        mem.delete();
        mem[32'h0] = 8'h34;
        mem[32'h1] = 8'h12;
        run_op("lods_wrap", CMD_LODS, 2'b00, 2'd1, 1'b1, 32'h77, 32'h0, 32'h0,
               32'hAABB_CCDD, 0);
        n_checks++;
        if ({eax_out, esi_out, ecx_out} !== {32'hAABB_1234, 32'hFFFF_FFFE, 32'h77}) begin
            n_errs++;
            $display("FAIL lods_wrap: got %h %h %h exp aabb1234 fffffffe 77", eax_out,
                     esi_out, ecx_out);
        end
    endtask

    task automatic test_stall_reset();
        mem.delete();
        cur_size   = 4;
        rsp_hold   = 1'b0;
        ready_mode = 2;
        @(negedge clk);
        opc = CMD_LODS; rep_kind = 2'b00; elem_size = 2'd2; df = 1'b0;
        ecx_in = 32'h5; esi_in = 32'h3000; edi_in = 32'h4000; eax_in = 32'h1;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({hint_req_valid, hint_req_is_write, hint_req_address, hint_req_data} !==
                {1'b1, 1'b0, 32'h3000, 32'h0}) begin
                n_errs++;
                $display("FAIL stall req %0d: got %b %b %h %h exp 1 0 3000 0", k,
                         hint_req_valid, hint_req_is_write, hint_req_address, hint_req_data);
            end
            @(negedge clk);
        end
        rsp_hold   = 1'b1;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({hint_req_valid, start_ready, done_valid} !== 3'b000) begin
            n_errs++;
            $display("FAIL stall wait: got %b%b%b exp 000", hint_req_valid, start_ready,
                     done_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({start_ready, hint_req_valid, hint_req_is_write, hint_req_address, hint_req_data,
             done_valid, ecx_out, esi_out, edi_out, eax_out, zf_out, iter_overflow} !==
            {1'b1, 197'd0}) begin
            n_errs++;
            $display("FAIL async reset: got r%b v%b a%h e%h s%h x%h exp r1 v0 all 0",
                     start_ready, hint_req_valid, hint_req_address, ecx_out, esi_out, eax_out);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        rsp_hold = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({start_ready, done_valid, hint_req_valid, eax_out} !== {3'b100, 32'd0}) begin
            n_errs++;
            $display("FAIL post reset: got %b%b%b %h exp 100 0", start_ready, done_valid,
                     hint_req_valid, eax_out);
        end
    endtask

    task automatic test_iter_limit();
        ready_mode = 0;
        mem.delete();
        run_op("stos_limit", CMD_STOS, 2'b01, 2'd2, 1'b0, 32'd10, 32'h0, 32'h500,
               32'hCAFE_F00D, 0);
`ifdef REP_ITER_LIMIT_EN
        n_checks++;
        if ({32'(obs_q.size()), ecx_out} !== {32'd4, 32'd6}) begin
            n_errs++;
            $display("FAIL stos_limit: got n%0d ecx %h exp n4 ecx 6", obs_q.size(), ecx_out);
        end
`else
        n_checks++;
        if ({32'(obs_q.size()), ecx_out} !== {32'd10, 32'd0}) begin
            n_errs++;
            $display("FAIL stos_nolimit: got n%0d ecx %h exp n10 ecx 0", obs_q.size(),
                     ecx_out);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] s, di, a, m;
        logic [1:0]  es;
        int          r;
        for (int k = 0; k < 40; k++) begin
            ready_mode = $urandom_range(0, 1);
            mem.delete();
            mem_seed = 8'($urandom);
            r  = $urandom_range(0, 5);
            op = (r == 5) ? (6'h20 + 6'($urandom_range(0, 31))) : (CMD_MOVS + 6'(r));
            es = 2'($urandom);
            m  = (es == 2'd0) ? 32'hFF : (es == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            s  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            // Same low address bits keep default memory patterns equal.
            di = {$urandom_range(0, 32'h3FFF_FFFF) > 0 ? 30'($urandom) : 30'd0, s[1:0]};
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = (a & ~m) | mem_elem(di, size_of(es));
            if ($urandom_range(0, 2) == 0) mem[di + 32'($urandom_range(0, 7))] = 8'($urandom);
            run_op($sformatf("rand%0d", k), op, 2'($urandom), es, 1'($urandom),
                   32'($urandom_range(0, 6)), s, di, a, $urandom_range(0, 2));
        end
    endtask

    initial begin
        fork
            responder();
        join_none
        test_reset();
        test_spec_examples();
        test_stall_reset();
        test_iter_limit();
        test_random();
        test_iter_limit();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
